mux_source_arbiter: RTL and testbench
=====================================

# mux_source_arbiter

Two-requester round-robin arbiter that owns the select line of the 7-bit 2-to-1 segment-pattern multiplexer in the createFace display path. Pattern source 1 (mux input `in1`) and pattern source 2 (mux input `in2`) each raise a request. The arbiter grants one source at a time and drives `select` to match the grant. A programmable minimum dwell time keeps the display from flickering between sources.

## Interface
- `HOLD_CYCLES`, default 25000000: minimum dwell, in clk cycles, before the owner can be preempted (0.5 s at 50 MHz). Legal range is 1 .. 2^CNT_W-1.
- `CNT_W`, default 25: width of the dwell counter.
- `clk`  input  1  system clock; all logic is rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `req1`  input  1  source 1 requests the display (level).
- `req2`  input  1  source 2 requests the display (level).
- `select`  output  1  mux select: 0 selects `in1`, 1 selects `in2`. Registered.
- `grant1`  output  1  source 1 owns the display. Registered.
- `grant2`  output  1  source 2 owns the display. Registered.
- `active`  output  1  `grant1 | grant2`. Registered.

## Operation
- FSM states:
  - IDLE: no grant.
  - G1: source 1 owns the display; `select`=0.
  - G2: source 2 owns the display; `select`=1.
- `last` flag records the most recently granted source. Reset value is 2, so source 1 wins first contention.
- Dwell counter:
  - Clears to 0 on every entry into G1 or G2.
  - Increments each cycle while in G1/G2.
  - Saturates at HOLD_CYCLES-1.
  - `expired` = (count == HOLD_CYCLES-1).
- IDLE transitions:
  - Only req1 → G1.
  - Only req2 → G2.
  - Both → the source that is not `last`.
  - Neither → stay in IDLE.
- Gx transitions, with own = req of the owner and other = req of the other source:
  - own=0 and other=1 → go to the other G state immediately, regardless of `expired`.
  - own=0 and other=0 → go to IDLE.
  - own=1, other=1 and `expired` → go to the other G state (round-robin preemption).
  - own=1 and (other=0 or not `expired`) → stay; counter saturates.
- `select` holds its last value in IDLE, so the mux output does not glitch. `select` changes only on entry to G1 (→0) or G2 (→1).
- `grant1` and `grant2` are mutually exclusive in every cycle.
- `last` updates on every entry into G1 or G2.

## Timing
- Reset values: state=IDLE, `select`=0, `grant1`=0, `grant2`=0, `active`=0, counter=0, `last`=2.
- Reset wins over all requests in the same cycle. Reset mid-grant drops grants in the next cycle.
- Request-to-grant latency: 1 cycle. A request sampled high at edge N gives a grant visible after edge N, i.e. in cycle N+1.
- Handover: at the deciding edge, the old grant deasserts and the new grant asserts. There is no dead cycle, and `select` flips at the same edge.
- With both sources requesting continuously, each owner holds for exactly HOLD_CYCLES cycles before switching.
- HOLD_CYCLES=1: `expired` is true on the first owned cycle, so constant contention alternates every cycle.
- Release latency: the owner dropping its request at edge N → grant low in cycle N+1.

## Structure
- Shared package `face_pkg`:
  - state encodings ST_IDLE=2'b00, ST_G1=2'b01, ST_G2=2'b10;
  - constants SRC1=1'b0 and SRC2=1'b1 (select values).
- Sub-module `dwell_timer`:
  - parameters HOLD_CYCLES and CNT_W;
  - inputs clk, rst, clear, run;
  - output `expired`;
  - saturating counter.
- Top level: FSM, `last` flag and output registers.
- Instantiated alongside the existing 2-to-1 mux, with `select` wired to the mux select.

## Test plan
All scenarios use HOLD_CYCLES=4 and CNT_W=3.
- Reset check: hold rst for 2 cycles with req1=req2=1 → all outputs 0, `select`=0. Release rst → `grant1`=1 one cycle later.
- Single requester: req2 pulses high for 10 cycles → `grant2`=1 and `select`=1 from the next cycle. One cycle after req2 falls, `grant2`=0 and `select` stays 1.
- Contention: req1 and req2 both held high from IDLE after reset → grants G1 for 4 cycles, G2 for 4, G1 for 4, and so on. `select` toggles every 4 cycles; grants never overlap.
- Early release: in G1 at cycle 2 of dwell, req1 drops while req2=1 → `grant2`=1 and `select`=1 the next cycle, with no IDLE cycle.
- Non-preemption: in G1 with req1=1, raise req2 at dwell cycle 1 → the switch occurs only after G1 has been held 4 cycles total.
- Reset mid-grant: assert rst while in G2 → next cycle all outputs 0, `select`=0, state IDLE. With req1=req2=1, source 1 is granted first after release.

Source files
------------

// File: rtl/mux_source_arbiter_pkg.sv
// Shared encodings for the createFace pattern-source arbiter.
// State codes and mux select values live here so the display path agrees on them.
package face_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_G1   = 2'b01,
      ST_G2   = 2'b10
   } state_e;

   localparam logic SRC1 = 1'b0;
   localparam logic SRC2 = 1'b1;

endpackage

// File: rtl/mux_source_arbiter_if.sv
// Request/grant bundle between the two pattern sources and the arbiter.
// The arbiter is the slave side; select feeds the 2-to-1 segment mux.
interface mux_source_arbiter_if;

   logic req1;
   logic req2;
   logic select;
   logic grant1;
   logic grant2;
   logic active;

   modport master (
      output req1, req2,
      input  select, grant1, grant2, active
   );

   modport slave (
      input  req1, req2,
      output select, grant1, grant2, active
   );

endinterface

// File: rtl/mux_source_arbiter_dwell_timer.sv
// Saturating dwell counter; expired marks the last cycle of the minimum hold.
// clear has priority so a handover restarts the dwell from zero.
module dwell_timer #(
   parameter int HOLD_CYCLES = 25000000,
   parameter int CNT_W       = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (run && !expired)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mux_source_arbiter.sv
// Round-robin owner of the createFace segment-mux select line.
// Grants and select are registered from the next state, so handover has no dead cycle.
module mux_source_arbiter
   import face_pkg::*;
#(
   parameter int HOLD_CYCLES = 25000000,
   parameter int CNT_W       = 25
) (
   input  logic                       clk,
   input  logic                       rst,
   mux_source_arbiter_if.slave        bus
);

   state_e state_q;
   state_e state_d;
   logic   last_q;
   logic   select_q;
   logic   grant1_q;
   logic   grant2_q;
   logic   active_q;
   logic   expired;
   logic   enter;

   assign enter = (state_d != state_q) && (state_d != ST_IDLE);

   dwell_timer #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
   ) u_dwell (
      .clk     (clk),
      .rst     (rst),
      .clear   (enter),
      .run     (state_q != ST_IDLE),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req1 && bus.req2)
               state_d = (last_q == SRC2) ? ST_G1 : ST_G2;
            else if (bus.req1)
               state_d = ST_G1;
            else if (bus.req2)
               state_d = ST_G2;
         end
         ST_G1: begin
            if (!bus.req1)
               state_d = bus.req2 ? ST_G2 : ST_IDLE;
            else if (bus.req2 && expired)
               state_d = ST_G2;
         end
         ST_G2: begin
            if (!bus.req2)
               state_d = bus.req1 ? ST_G1 : ST_IDLE;
            else if (bus.req1 && expired)
               state_d = ST_G1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // select only moves on entry to an owned state; IDLE keeps the mux steady
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         last_q   <= SRC2;
         select_q <= SRC1;
         grant1_q <= 1'b0;
         grant2_q <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant1_q <= (state_d == ST_G1);
         grant2_q <= (state_d == ST_G2);
         active_q <= (state_d != ST_IDLE);
         if (enter) begin
            last_q   <= (state_d == ST_G2) ? SRC2 : SRC1;
            select_q <= (state_d == ST_G2) ? SRC2 : SRC1;
         end
      end
   end

   assign bus.select = select_q;
   assign bus.grant1 = grant1_q;
   assign bus.grant2 = grant2_q;
   assign bus.active = active_q;

endmodule

// File: tb/tb_mux_source_arbiter.sv
// Directed-vector scoreboard bench for mux_source_arbiter with HOLD_CYCLES=4.
// Each vector carries its inputs and the hand-derived outputs seen after that edge.
module tb_mux_source_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mux_source_arbiter_if bus_if ();

   mux_source_arbiter #(
      .HOLD_CYCLES (4),
      .CNT_W       (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [3:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  applied = 0;
   int  miscompares = 0;

   // {rst, req1, req2, select, grant1, grant2, active}
   localparam int NV = 39;
   logic [6:0] vecs [NV] = '{
      7'b111_0000, 7'b111_0000,
      7'b011_0101, 7'b011_0101, 7'b011_0101, 7'b011_0101,
      7'b011_1011, 7'b011_1011, 7'b011_1011, 7'b011_1011,
      7'b011_0101, 7'b011_0101, 7'b011_0101, 7'b011_0101,
      7'b011_1011,
      7'b111_0000,
      7'b011_0101, 7'b011_0101,
      7'b001_1011,
      7'b000_1000, 7'b000_1000,
      7'b001_1011, 7'b001_1011, 7'b001_1011, 7'b001_1011,
      7'b001_1011,
      7'b000_1000,
      7'b010_0101,
      7'b011_0101, 7'b011_0101, 7'b011_0101,
      7'b011_1011,
      7'b000_1000,
      7'b010_0101,
      7'b000_0000,
      7'b011_1011,
      7'b111_0000,
      7'b011_0101,
      7'b000_0000
   };

   initial begin
      bus_if.req1 = 1'b0;
      bus_if.req2 = 1'b0;
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst         = vecs[i][6];
         bus_if.req1 = vecs[i][5];
         bus_if.req2 = vecs[i][4];
         sb_q.push_back('{idx: i, exp: vecs[i][3:0]});
      end
      @(negedge clk);
      @(negedge clk);
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               applied, miscompares);
      $finish;
   end

   initial begin
      forever begin
         logic [3:0] act;
         sb_t        e;
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {bus_if.select, bus_if.grant1,
                   bus_if.grant2, bus_if.active};
            applied++;
            if (act !== e.exp) begin
               miscompares++;
               $display("FAIL vec%0d: sel/g1/g2/act got %b, required %b",
                        e.idx, act, e.exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
